// File: rtl/regfile_read_port.sv
// Register file read side: 8x16 storage fed by the write-back stream, with a single
// read port sequenced over two cycles to fetch an A/B operand pair for the ALU.
module regfile_read_port #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             write,
    input  logic [AW-1:0]    writenum,
    input  logic [WIDTH-1:0] data_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    rnum_a,
    input  logic [AW-1:0]    rnum_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out
);

    localparam int NREG = 1 << AW;

    typedef enum logic [1:0] {
        IDLE,
        READ_A,
        READ_B,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [AW-1:0]    ra_q, ra_d;
    logic [AW-1:0]    rb_q, rb_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    // Write-back always lands, regardless of what the read sequencer is doing.
    always_comb begin
        regs_d = regs_q;
        if (write) begin
            regs_d[writenum] = data_in;
        end
    end

    // Single read port; a same-cycle write to the addressed register is forwarded.
    always_comb begin
        rd_addr = (state_q == READ_B) ? rb_q : ra_q;
        if (write && (writenum == rd_addr)) begin
            rd_data = data_in;
        end else begin
            rd_data = regs_q[rd_addr];
        end
    end

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ra_d    = rnum_a;
                    rb_d    = rnum_b;
                    state_d = READ_A;
                end
            end
            READ_A: begin
                a_d     = rd_data;
                state_d = READ_B;
            end
            READ_B: begin
                b_d     = rd_data;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            a_q     <= a_d;
            b_q     <= b_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign a_out     = a_q;
    assign b_out     = b_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed self-checking bench for regfile_read_port: reset, fetch, bypass,
// backpressure/snapshot, same-register reads and asynchronous reset mid-fetch.
module tb_regfile_read_port;

    localparam int WIDTH = 16;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             write;
    logic [AW-1:0]    writenum;
    logic [WIDTH-1:0] data_in;
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    rnum_a;
    logic [AW-1:0]    rnum_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;

    int check_cnt = 0;
    int pass_cnt  = 0;

    regfile_read_port #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .write    (write),
        .writenum (writenum),
        .data_in  (data_in),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .rnum_a   (rnum_a),
        .rnum_b   (rnum_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a_out    (a_out),
        .b_out    (b_out)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] idx, input logic [WIDTH-1:0] val);
        write    = 1'b1;
        writenum = idx;
        data_in  = val;
        step();
        write    = 1'b0;
    endtask

    // Issue a request and stop right after the edge that enters HOLD.
    task automatic fetch(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        req_valid = 1'b1;
        rnum_a    = ra;
        rnum_b    = rb;
        step();
        req_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        check_cnt++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid);
        else pass_cnt++;
        check_cnt++;
        if (a_out !== 16'h0000 || b_out !== 16'h0000)
            $display("[TB] FAIL reset_ab got %h/%h want 0000/0000", a_out, b_out);
        else pass_cnt++;
        step();
        reset_n = 1'b1;
        step();
        check_cnt++;
        if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready got %0b want 1", req_ready);
        else pass_cnt++;

        out_ready = 1'b1;
        req_valid = 1'b1;
        rnum_a    = 3'd3;
        rnum_b    = 3'd5;
        step();
        req_valid = 1'b0;
        check_cnt++;
        if (req_ready !== 1'b0 || out_valid !== 1'b0)
            $display("[TB] FAIL reset_read_t1 got rdy=%0b vld=%0b want 0/0", req_ready, out_valid);
        else pass_cnt++;
        step();
        check_cnt++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_read_t2 got vld=%0b want 0", out_valid);
        else pass_cnt++;
        step();
        check_cnt++;
        if (out_valid !== 1'b1 || a_out !== 16'h0000 || b_out !== 16'h0000)
            $display("[TB] FAIL reset_read_t3 got vld=%0b a=%h b=%h want 1/0000/0000",
                     out_valid, a_out, b_out);
        else pass_cnt++;
        step();
        check_cnt++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1)
            $display("[TB] FAIL reset_read_t4 got vld=%0b rdy=%0b want 0/1", out_valid, req_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic_fetch();
        write_reg(3'd3, 16'h1234);
        write_reg(3'd5, 16'hBEEF);
        req_valid = 1'b1;
        rnum_a    = 3'd3;
        rnum_b    = 3'd5;
        step();
        req_valid = 1'b0;
        check_cnt++;
        if (req_ready !== 1'b0) $display("[TB] FAIL basic_busy1 got %0b want 0", req_ready);
        else pass_cnt++;
        step();
        check_cnt++;
        if (req_ready !== 1'b0 || out_valid !== 1'b0)
            $display("[TB] FAIL basic_busy2 got rdy=%0b vld=%0b want 0/0", req_ready, out_valid);
        else pass_cnt++;
        step();
        check_cnt++;
        if (out_valid !== 1'b1 || a_out !== 16'h1234 || b_out !== 16'hBEEF || req_ready !== 1'b0)
            $display("[TB] FAIL basic_pair got vld=%0b a=%h b=%h rdy=%0b want 1/1234/beef/0",
                     out_valid, a_out, b_out, req_ready);
        else pass_cnt++;
        step();
        check_cnt++;
        if (req_ready !== 1'b1 || a_out !== 16'h1234 || b_out !== 16'hBEEF)
            $display("[TB] FAIL basic_idle got rdy=%0b a=%h b=%h want 1/1234/beef",
                     req_ready, a_out, b_out);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        write_reg(3'd2, 16'h0001);
        req_valid = 1'b1;
        rnum_a    = 3'd2;
        rnum_b    = 3'd0;
        step();
        req_valid = 1'b0;
        write     = 1'b1;
        writenum  = 3'd2;
        data_in   = 16'h00AA;
        step();
        write     = 1'b0;
        step();
        check_cnt++;
        if (a_out !== 16'h00AA || b_out !== 16'h0000)
            $display("[TB] FAIL bypass_a got a=%h b=%h want 00aa/0000", a_out, b_out);
        else pass_cnt++;
        step();
        fetch(3'd7, 3'd2);
        check_cnt++;
        if (b_out !== 16'h00AA) $display("[TB] FAIL bypass_stored got %h want 00aa", b_out);
        else pass_cnt++;
        step();
    endtask

    task automatic test_backpressure();
        write_reg(3'd1, 16'h1111);
        write_reg(3'd4, 16'h4444);
        out_ready = 1'b0;
        fetch(3'd1, 3'd4);
        check_cnt++;
        if (out_valid !== 1'b1 || a_out !== 16'h1111 || b_out !== 16'h4444)
            $display("[TB] FAIL bp_pair got vld=%0b a=%h b=%h want 1/1111/4444",
                     out_valid, a_out, b_out);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                write    = 1'b1;
                writenum = 3'd1;
                data_in  = 16'h9999;
            end
            req_valid = 1'b1;
            step();
            write     = 1'b0;
            req_valid = 1'b0;
            check_cnt++;
            if (out_valid !== 1'b1 || a_out !== 16'h1111 || req_ready !== 1'b0)
                $display("[TB] FAIL bp_hold%0d got vld=%0b a=%h rdy=%0b want 1/1111/0",
                         i, out_valid, a_out, req_ready);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        step();
        check_cnt++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1)
            $display("[TB] FAIL bp_handoff got vld=%0b rdy=%0b want 0/1", out_valid, req_ready);
        else pass_cnt++;
        fetch(3'd1, 3'd4);
        check_cnt++;
        if (a_out !== 16'h9999) $display("[TB] FAIL bp_written got %h want 9999", a_out);
        else pass_cnt++;
        step();
    endtask

    task automatic test_same_reg();
        write_reg(3'd6, 16'h0006);
        req_valid = 1'b1;
        rnum_a    = 3'd6;
        rnum_b    = 3'd6;
        step();
        req_valid = 1'b0;
        step();
        write    = 1'b1;
        writenum = 3'd6;
        data_in  = 16'h0060;
        step();
        write    = 1'b0;
        check_cnt++;
        if (a_out !== 16'h0006 || b_out !== 16'h0060)
            $display("[TB] FAIL same_reg got a=%h b=%h want 0006/0060", a_out, b_out);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid();
        write_reg(3'd7, 16'hFFFF);
        req_valid = 1'b1;
        rnum_a    = 3'd7;
        rnum_b    = 3'd7;
        step();
        req_valid = 1'b0;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check_cnt++;
        if (out_valid !== 1'b0 || a_out !== 16'h0000 || b_out !== 16'h0000)
            $display("[TB] FAIL mid_reset got vld=%0b a=%h b=%h want 0/0000/0000",
                     out_valid, a_out, b_out);
        else pass_cnt++;
        step();
        reset_n = 1'b1;
        step();
        check_cnt++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL mid_release got rdy=%0b vld=%0b want 1/0", req_ready, out_valid);
        else pass_cnt++;
        fetch(3'd7, 3'd3);
        check_cnt++;
        if (out_valid !== 1'b1 || a_out !== 16'h0000 || b_out !== 16'h0000)
            $display("[TB] FAIL mid_cleared got vld=%0b a=%h b=%h want 1/0000/0000",
                     out_valid, a_out, b_out);
        else pass_cnt++;
        step();
        write_reg(3'd7, 16'hA5C3);
        fetch(3'd0, 3'd7);
        check_cnt++;
        if (a_out !== 16'h0000 || b_out !== 16'hA5C3)
            $display("[TB] FAIL mid_next got a=%h b=%h want 0000/a5c3", a_out, b_out);
        else pass_cnt++;
        step();
    endtask

    initial begin
        reset_n   = 1'b0;
        write     = 1'b0;
        writenum  = '0;
        data_in   = '0;
        req_valid = 1'b0;
        rnum_a    = '0;
        rnum_b    = '0;
        out_ready = 1'b1;
        #2;
        test_reset();
        test_basic_fetch();
        test_bypass();
        test_backpressure();
        test_same_reg();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
